dist_1_2: RTL and testbench
===========================

Name: dist_1_2

Overview:
- Registered 1-to-2 stream distributor: the demultiplexing counterpart of the 2:1 selector.
- Each accepted input word goes to output A or output B, selected by SEL or by automatic alternation.
- Each output has one valid/ready register stage, so a stalled output never corrupts the other.
- Sits between a single producer and two consumer lanes; per-lane transfer counters are provided for debug.

Parameters:
- WIDTH, 8, data width of the input and of each output lane.
- CW, 16, width of the per-lane transfer counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- IN_DATA  in  WIDTH  input word.
- IN_VALID  in  1  input word present.
- IN_READY  out  1  input word accepted this cycle when IN_VALID=1.
- SEL  in  1  lane select: 0 routes to A, 1 routes to B. Ignored when ALT=1.
- ALT  in  1  alternate mode: lanes used in turn A, B, A, ...
- OUT_A_DATA  out  WIDTH  lane A word.
- OUT_A_VALID  out  1  lane A word present.
- OUT_A_READY  in  1  lane A consumer accepts.
- OUT_B_DATA  out  WIDTH  lane B word.
- OUT_B_VALID  out  1  lane B word present.
- OUT_B_READY  in  1  lane B consumer accepts.
- CNT_A  out  CW  count of words delivered on lane A.
- CNT_B  out  CW  count of words delivered on lane B.

Behaviour:
- Reset, on any CLK edge with RST=1:
  - OUT_x_VALID=0, OUT_x_DATA=0, CNT_A=CNT_B=0, alternation pointer PTR=0 (lane A).
  - Reset mid-operation discards held words without delivering them.
  - IN_READY=0 while RST=1.
- Target lane (combinational): TGT = ALT ? PTR : SEL.
- Lane stage states: EMPTY (VALID=0) and FULL (VALID=1).
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain (VALID & READY) with no load.
  - FULL -> FULL on drain and load in the same cycle: the new word replaces the old one and VALID stays 1.
  - FULL with no drain: DATA is held stable and VALID stays 1.
- Handshake rules:
  - IN_READY = !RST & (target lane EMPTY, or target lane FULL and draining this cycle).
  - Input transfer = IN_VALID & IN_READY; it loads IN_DATA into the target lane.
  - IN_READY depends combinationally on the target lane's READY (pass-through path). There is no combinational path from IN_VALID to IN_READY.
  - The non-target lane's state never affects IN_READY: a stalled B does not block traffic routed to A.
  - OUT_x_VALID never depends combinationally on OUT_x_READY.
- Latency and throughput:
  - A word accepted at edge N appears with OUT_x_VALID=1 in the cycle after edge N.
  - Each lane sustains one word per cycle when its READY is held at 1.
- SEL and ALT:
  - SEL may change on any cycle; no stability is required while IN_READY=0.
  - PTR toggles on each input transfer while ALT=1. It is not modified while ALT=0 and is not cleared when ALT changes.
- Counters:
  - CNT_x increments on each lane-x drain (OUT_x_VALID & OUT_x_READY).
  - Wraps from 2^CW-1 to 0.
  - Both lanes may drain in the same cycle; both counters increment independently.
- Boundary conditions:
  - Ordering is preserved within each lane. There is no ordering guarantee between lanes.
  - IN_VALID=0: no state change except drains.
  - Target lane FULL with READY=0: IN_READY=0, PTR is held, and the word waits (head-of-line blocking).

Decomposition:
- Shared package: default WIDTH and CW constants; lane encoding constants LANE_A=0, LANE_B=1.
- Sub-module: dist_out_stage, a single-entry valid/ready register slice. Inputs: load, data, ready. Outputs: valid, data, accept_ok (empty or draining). It contains the lane counter and is instantiated twice.
- Top level holds only the target mux, PTR and IN_READY logic.

Test Plan:
- Reset check: RST=1 for 2 cycles with IN_VALID=1 and data 0x55 -> IN_READY=0, both VALID=0, CNT_A=CNT_B=0; after release, first word accepted on the next edge.
- SEL routing: ALT=0, SEL=0 data 0x11, then SEL=1 data 0x22, both READY=1 -> OUT_A shows 0x11 one cycle after acceptance, OUT_B shows 0x22, CNT_A=1, CNT_B=1.
- Independent stall: OUT_B_READY=0 and lane B FULL with 0x22; send SEL=0 words 0x30..0x33 -> all delivered on A back-to-back, IN_READY=1 throughout; OUT_B_DATA held at 0x22.
- Head-of-line blocking: lane A FULL with READY=0, SEL=0 word 0x44 pending -> IN_READY=0 until OUT_A_READY=1; in that cycle 0x44 loads while the old word drains, and VALID stays 1.
- Alternate mode: ALT=1, 6 words 0x01..0x06 with both READY=1 -> A receives 0x01, 0x03, 0x05 and B receives 0x02, 0x04, 0x06. Then stall A while the next target is A -> PTR holds and IN_READY=0.
- Counter wrap and mid-operation reset: CW=4, 17 drains on A -> CNT_A reads 1. Assert RST while both lanes are FULL -> VALIDs drop to 0 and the held words are never presented.

Source files
------------

// File: rtl/dist_1_2_pkg.sv
// dist_1_2_pkg: shared constants and lane stage state for the 1-to-2 stream distributor
package dist_1_2_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CW = 16;
  localparam logic LANE_A = 1'b0;
  localparam logic LANE_B = 1'b1;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_t;
endpackage

// File: rtl/dist_out_stage.sv
// dist_out_stage: single-entry valid/ready slice with drain counter; ports clk, rst, load, din, ready -> valid, dout, accept_ok, cnt
module dist_out_stage
  import dist_1_2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             accept_ok,
  output logic [CW-1:0]    cnt
);
  stage_t state, state_nx;
  logic drain;
  assign valid = (state == FULL);
  assign drain = valid & ready;
  assign accept_ok = !valid | ready;
  always_comb state_nx = load ? FULL : drain ? EMPTY : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      dout <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (load) dout <= din;
      if (drain) cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/dist_1_2.sv
// dist_1_2: registered 1-to-2 stream distributor; in_* stream routed by sel/alt to out_a_*/out_b_*, cnt_a/cnt_b count lane deliveries
module dist_1_2
  import dist_1_2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic             alt,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [CW-1:0]    cnt_a,
  output logic [CW-1:0]    cnt_b
);
  logic ptr, tgt, xfer, ok_a, ok_b;
  assign tgt = alt ? ptr : sel;
  // only the target lane gates acceptance, so a stalled other lane never blocks
  assign in_ready = !rst & (tgt == LANE_B ? ok_b : ok_a);
  assign xfer = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (rst) ptr <= LANE_A;
    else if (alt & xfer) ptr <= ~ptr;
  end
  dist_out_stage #(.WIDTH(WIDTH), .CW(CW)) stage_a (
    .clk(clk), .rst(rst), .load(xfer & (tgt == LANE_A)), .din(in_data), .ready(out_a_ready),
    .valid(out_a_valid), .dout(out_a_data), .accept_ok(ok_a), .cnt(cnt_a)
  );
  dist_out_stage #(.WIDTH(WIDTH), .CW(CW)) stage_b (
    .clk(clk), .rst(rst), .load(xfer & (tgt == LANE_B)), .din(in_data), .ready(out_b_ready),
    .valid(out_b_valid), .dout(out_b_data), .accept_ok(ok_b), .cnt(cnt_b)
  );
endmodule

// File: tb/tb_dist_1_2.sv
// tb_dist_1_2: randomized and directed bench for dist_1_2 against a queue-based lane model
module tb_dist_1_2;
  localparam int W = 8;
  localparam int CW = 4;
  logic clk = 0, rst;
  logic [W-1:0] in_data, out_a_data, out_b_data;
  logic in_valid, in_ready, sel, alt;
  logic out_a_valid, out_a_ready, out_b_valid, out_b_ready;
  logic [CW-1:0] cnt_a, cnt_b;
  int n_chk = 0, n_pass = 0;
  logic [W-1:0] qa[$], qb[$];
  bit mptr = 0;
  int ca = 0, cb = 0;
  dist_1_2 #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .alt(alt), .out_a_data(out_a_data), .out_a_valid(out_a_valid),
    .out_a_ready(out_a_ready), .out_b_data(out_b_data), .out_b_valid(out_b_valid),
    .out_b_ready(out_b_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic cycle(input bit r, input bit iv, input logic [W-1:0] d, input bit s,
                       input bit al, input bit ra, input bit rb);
    bit tgt, exp_rdy;
    rst = r; in_valid = iv; in_data = d; sel = s; alt = al; out_a_ready = ra; out_b_ready = rb;
    #1;
    tgt = al ? mptr : s;
    exp_rdy = !r && (tgt ? (qb.size() == 0 || rb) : (qa.size() == 0 || ra));
    chk("in_ready", in_ready, exp_rdy);
    chk("a_valid", out_a_valid, qa.size() != 0);
    chk("b_valid", out_b_valid, qb.size() != 0);
    if (qa.size() != 0) chk("a_data", out_a_data, qa[0]);
    if (qb.size() != 0) chk("b_data", out_b_data, qb[0]);
    chk("cnt_a", cnt_a, ca);
    chk("cnt_b", cnt_b, cb);
    if (r) begin
      qa.delete(); qb.delete(); mptr = 0; ca = 0; cb = 0;
    end else begin
      if (qa.size() != 0 && ra) begin void'(qa.pop_front()); ca = (ca + 1) % (1 << CW); end
      if (qb.size() != 0 && rb) begin void'(qb.pop_front()); cb = (cb + 1) % (1 << CW); end
      if (iv && exp_rdy) begin
        if (tgt) qb.push_back(d); else qa.push_back(d);
        if (al) mptr = !mptr;
      end
    end
    @(posedge clk); #1;
  endtask
  initial begin
    rst = 1; in_valid = 1; in_data = 8'h55; sel = 0; alt = 0; out_a_ready = 1; out_b_ready = 1;
    @(posedge clk); #1;
    repeat (2) cycle(1, 1, 8'h55, 0, 0, 1, 1);
    chk("rst_a_data", out_a_data, 0);
    chk("rst_b_data", out_b_data, 0);
    cycle(0, 1, 8'h11, 0, 0, 1, 1);
    cycle(0, 1, 8'h22, 1, 0, 1, 1);
    repeat (2) cycle(0, 0, 8'h00, 0, 0, 1, 1);
    chk("sel_cnt_a", cnt_a, 1);
    chk("sel_cnt_b", cnt_b, 1);
    cycle(0, 1, 8'h22, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h30 + 8'(i), 0, 0, 1, 0);
    cycle(0, 0, 8'h00, 0, 0, 1, 0);
    chk("stall_b_held", out_b_data, 8'h22);
    cycle(0, 1, 8'h40, 0, 0, 0, 1);
    repeat (3) cycle(0, 1, 8'h44, 0, 0, 0, 1);
    cycle(0, 1, 8'h44, 0, 0, 1, 1);
    chk("hol_a_data", out_a_data, 8'h44);
    repeat (2) cycle(0, 0, 8'h00, 0, 0, 1, 1);
    for (int i = 1; i <= 6; i++) cycle(0, 1, 8'(i), 0, 1, 1, 1);
    cycle(0, 1, 8'h07, 1, 1, 0, 1);
    cycle(0, 1, 8'h08, 0, 1, 0, 1);
    repeat (3) cycle(0, 1, 8'h09, 1, 1, 0, 1);
    cycle(0, 1, 8'h09, 1, 1, 1, 1);
    cycle(0, 0, 8'h00, 0, 0, 0, 0);
    cycle(0, 1, 8'hA1, 0, 0, 0, 0);
    cycle(0, 1, 8'hB1, 1, 0, 0, 0);
    cycle(1, 0, 8'h00, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 8'h00, 0, 0, 1, 1);
    for (int i = 0; i < 17; i++) cycle(0, 1, 8'(8'h60 + i), 0, 0, 1, 1);
    cycle(0, 0, 8'h00, 0, 0, 1, 1);
    chk("cnt_a_wrap", cnt_a, 1);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
            1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) != 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
